// File: rtl/riscmakers_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscmakers_icache_tag_ctrl
// Brief    : Instruction-cache tag store access sequencer (invalidation sweep,
//            refill writes, pipelined hit/miss lookups).
// Revision : 1.0 - initial release
// ============================================================================
module riscmakers_icache_tag_ctrl #(
    parameter int TAG_WIDTH     = 20,
    parameter int DATA_WIDTH    = 24,
    parameter int VALID_BIT_POS = 23,
    parameter int NUM_WORDS     = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         busy_o,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [$clog2(NUM_WORDS)-1:0] req_index_i,
    input  logic [TAG_WIDTH-1:0]         req_tag_i,
    output logic                         rsp_valid_o,
    output logic                         rsp_hit_o,
    input  logic                         refill_valid_i,
    output logic                         refill_ready_o,
    input  logic [$clog2(NUM_WORDS)-1:0] refill_index_i,
    input  logic [TAG_WIDTH-1:0]         refill_tag_i,
    output logic                         tag_en_o,
    output logic                         tag_we_o,
    output logic [DATA_WIDTH/8-1:0]      tag_be_o,
    output logic [$clog2(NUM_WORDS)-1:0] tag_addr_o,
    output logic [DATA_WIDTH-1:0]        tag_wdata_o,
    input  logic [DATA_WIDTH-1:0]        tag_rdata_i
);

    localparam int c_IDX_W = $clog2(NUM_WORDS);
    localparam int c_BE_W  = DATA_WIDTH / 8;

    localparam logic [0:0] c_ST_SWEEP = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);

    logic [0:0]           r_state;
    logic [c_IDX_W-1:0]   r_sweep_idx;
    logic                 r_rsp_pending;
    logic [TAG_WIDTH-1:0] r_req_tag;

    logic                  w_sweeping;
    logic                  w_serve;
    logic                  w_lookup_go;
    logic                  w_tag_match;
    logic [DATA_WIDTH-1:0] w_refill_wdata;
    logic                  w_unused_rdata;

    // Everything is gated by rst_ni so the SRAM sees no strobes during reset.
    assign w_sweeping     = rst_ni && (r_state == c_ST_SWEEP);
    assign w_serve        = rst_ni && (r_state == c_ST_IDLE) && !flush_i;
    assign refill_ready_o = w_serve && refill_valid_i;
    assign req_ready_o    = w_serve && !refill_valid_i;
    assign w_lookup_go    = req_ready_o && req_valid_i;
    assign busy_o         = !rst_ni || (r_state == c_ST_SWEEP);

    assign rsp_valid_o    = rst_ni && r_rsp_pending;
    assign w_tag_match    = (tag_rdata_i[TAG_WIDTH-1:0] == r_req_tag);
    assign rsp_hit_o      = rsp_valid_o && tag_rdata_i[VALID_BIT_POS] && w_tag_match;
    assign w_unused_rdata = ^tag_rdata_i;

    always_comb begin
        w_refill_wdata                  = '0;
        w_refill_wdata[TAG_WIDTH-1:0]   = refill_tag_i;
        w_refill_wdata[VALID_BIT_POS]   = 1'b1;
    end

    always_comb begin
        tag_en_o    = 1'b0;
        tag_we_o    = 1'b0;
        tag_be_o    = '0;
        tag_addr_o  = '0;
        tag_wdata_o = '0;
        if (w_sweeping) begin
            tag_en_o   = 1'b1;
            tag_we_o   = 1'b1;
            tag_be_o   = {c_BE_W{1'b1}};
            tag_addr_o = r_sweep_idx;
        end else if (refill_ready_o) begin
            tag_en_o    = 1'b1;
            tag_we_o    = 1'b1;
            tag_be_o    = {c_BE_W{1'b1}};
            tag_addr_o  = refill_index_i;
            tag_wdata_o = w_refill_wdata;
        end else if (w_lookup_go) begin
            tag_en_o   = 1'b1;
            tag_addr_o = req_index_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= c_ST_SWEEP;
            r_sweep_idx   <= '0;
            r_rsp_pending <= 1'b0;
        end else begin
            r_rsp_pending <= w_lookup_go;
            case (r_state)
                c_ST_SWEEP: begin
                    if (r_sweep_idx == c_LAST_IDX) begin
                        r_state     <= c_ST_IDLE;
                        r_sweep_idx <= '0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + c_IDX_W'(1);
                    end
                end
                c_ST_IDLE: begin
                    if (flush_i) begin
                        r_state <= c_ST_SWEEP;
                    end
                end
                default: r_state <= c_ST_SWEEP;
            endcase
        end
    end

    // Tag is held for the one-cycle compare against the returning read data.
    always_ff @(posedge clk_i) begin
        if (w_lookup_go) begin
            r_req_tag <= req_tag_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscmakers_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscmakers_icache_tag_ctrl
// Brief    : Directed and random bench for the icache tag store controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscmakers_icache_tag_ctrl;

    localparam int TW = 20;
    localparam int DW = 24;
    localparam int VB = 23;
    localparam int NW = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          busy_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [5:0]    req_index_i;
    logic [TW-1:0] req_tag_i;
    logic          rsp_valid_o;
    logic          rsp_hit_o;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [5:0]    refill_index_i;
    logic [TW-1:0] refill_tag_i;
    logic          tag_en_o;
    logic          tag_we_o;
    logic [2:0]    tag_be_o;
    logic [5:0]    tag_addr_o;
    logic [DW-1:0] tag_wdata_o;
    logic [DW-1:0] tag_rdata_i = '0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk_i = ~clk_i;

    riscmakers_icache_tag_ctrl #(
        .TAG_WIDTH    (TW),
        .DATA_WIDTH   (DW),
        .VALID_BIT_POS(VB),
        .NUM_WORDS    (NW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_index_i   (req_index_i),
        .req_tag_i     (req_tag_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_hit_o     (rsp_hit_o),
        .refill_valid_i(refill_valid_i),
        .refill_ready_o(refill_ready_o),
        .refill_index_i(refill_index_i),
        .refill_tag_i  (refill_tag_i),
        .tag_en_o      (tag_en_o),
        .tag_we_o      (tag_we_o),
        .tag_be_o      (tag_be_o),
        .tag_addr_o    (tag_addr_o),
        .tag_wdata_o   (tag_wdata_o),
        .tag_rdata_i   (tag_rdata_i)
    );

    // Tag store SRAM: read data only changes on a read.
    logic [DW-1:0] mem [NW];
    always @(posedge clk_i) begin
        if (tag_en_o) begin
            if (tag_we_o) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (tag_be_o[b]) mem[tag_addr_o][b*8 +: 8] <= tag_wdata_o[b*8 +: 8];
                end
            end else begin
                tag_rdata_i <= mem[tag_addr_o];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Abstract reference: per-set valid/tag, remaining sweep cycles, one pending answer.
    bit          m_valid [NW];
    int          m_tag   [NW];
    int          m_sweep_left = NW;
    bit          m_pend = 1'b0;
    bit          m_pend_hit = 1'b0;

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_sweep_left <= NW;
            m_pend       <= 1'b0;
            for (int i = 0; i < NW; i++) m_valid[i] <= 1'b0;
        end else begin
            m_pend     <= req_valid_i && m_sweep_left == 0 && !flush_i && !refill_valid_i;
            m_pend_hit <= m_valid[req_index_i] && (m_tag[req_index_i] == int'(req_tag_i));
            if (m_sweep_left == 0 && !flush_i && refill_valid_i) begin
                m_valid[refill_index_i] <= 1'b1;
                m_tag[refill_index_i]   <= int'(refill_tag_i);
            end
            if (m_sweep_left > 0) begin
                m_sweep_left <= m_sweep_left - 1;
            end else if (flush_i) begin
                m_sweep_left <= NW;
                for (int i = 0; i < NW; i++) m_valid[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        bit            idle;
        logic          e_en, e_we;
        logic [2:0]    e_be;
        logic [5:0]    e_addr;
        logic [DW-1:0] e_wd;
        if (chk_en) begin
            idle   = (m_sweep_left == 0);
            e_en   = 1'b0;
            e_we   = 1'b0;
            e_be   = 3'b000;
            e_addr = 6'd0;
            e_wd   = '0;
            if (rst_ni && !idle) begin
                e_en   = 1'b1;
                e_we   = 1'b1;
                e_be   = 3'b111;
                e_addr = 6'(NW - m_sweep_left);
            end else if (rst_ni && !flush_i && refill_valid_i) begin
                e_en   = 1'b1;
                e_we   = 1'b1;
                e_be   = 3'b111;
                e_addr = refill_index_i;
                e_wd   = (24'd1 << VB) | 24'(refill_tag_i);
            end else if (rst_ni && !flush_i && req_valid_i) begin
                e_en   = 1'b1;
                e_addr = req_index_i;
            end
            chk("busy",         32'(busy_o),         32'(!rst_ni || !idle));
            chk("req_ready",    32'(req_ready_o),    32'(rst_ni && idle && !flush_i && !refill_valid_i));
            chk("refill_ready", 32'(refill_ready_o), 32'(rst_ni && idle && !flush_i && refill_valid_i));
            chk("rsp_valid",    32'(rsp_valid_o),    32'(rst_ni && m_pend));
            chk("rsp_hit",      32'(rsp_hit_o),      32'(rst_ni && m_pend && m_pend_hit));
            chk("tag_en",       32'(tag_en_o),       32'(e_en));
            chk("tag_we",       32'(tag_we_o),       32'(e_we));
            chk("tag_be",       32'(tag_be_o),       32'(e_be));
            chk("tag_addr",     32'(tag_addr_o),     32'(e_addr));
            chk("tag_wdata",    32'(tag_wdata_o),    32'(e_wd));
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_i);
        while (busy_o && n < 200) begin
            cyc();
            @(negedge clk_i);
            n++;
        end
        chk("idle_timeout", 32'(busy_o), 32'd0);
        cyc();
    endtask

    initial begin
        int nwr   = 0;
        int nbusy = 0;
        int n     = 0;
        rst_ni = 1'b0; flush_i = 1'b0;
        req_valid_i = 1'b0; req_index_i = '0; req_tag_i = '0;
        refill_valid_i = 1'b0; refill_index_i = '0; refill_tag_i = '0;
        @(posedge clk_i);
        chk_en = 1'b1;
        cyc();
        @(negedge clk_i);
        chk("rst_busy",   32'(busy_o),      32'd1);
        chk("rst_tag_en", 32'(tag_en_o),    32'd0);
        chk("rst_ready",  32'(req_ready_o), 32'd0);
        cyc();

        // Reset release: 64 sweep writes, ready in cycle 64.
        rst_ni = 1'b1;
        for (int c = 0; c <= NW; c++) begin
            @(negedge clk_i);
            if (tag_en_o && tag_we_o && tag_wdata_o == '0 && tag_addr_o == 6'(c)) nwr++;
            if (busy_o) nbusy++;
            if (c == NW) chk("ready_cycle64", 32'(req_ready_o), 32'd1);
            cyc();
        end
        chk("sweep_writes", 32'(nwr),   32'd64);
        chk("busy_cycles",  32'(nbusy), 32'd64);

        // Refill (5,0x3A), then lookups hit / miss back to back.
        refill_valid_i = 1'b1; refill_index_i = 6'd5; refill_tag_i = 20'h3A;
        cyc();
        refill_valid_i = 1'b0;
        req_valid_i = 1'b1; req_index_i = 6'd5; req_tag_i = 20'h3A;
        cyc();
        req_tag_i = 20'h3B;
        @(negedge clk_i);
        chk("hit_5_3A", 32'({rsp_valid_o, rsp_hit_o}), 32'b11);
        cyc();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("miss_5_3B", 32'({rsp_valid_o, rsp_hit_o}), 32'b10);
        cyc();

        // Refill wins over a simultaneous lookup of the same entry.
        refill_valid_i = 1'b1; refill_index_i = 6'd7; refill_tag_i = 20'h11;
        req_valid_i = 1'b1; req_index_i = 6'd7; req_tag_i = 20'h11;
        @(negedge clk_i);
        chk("refill_prio", 32'({refill_ready_o, req_ready_o}), 32'b10);
        cyc();
        refill_valid_i = 1'b0;
        cyc();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("hit_7_11", 32'({rsp_valid_o, rsp_hit_o}), 32'b11);
        cyc();

        // Flush in the response cycle: response still delivered, then sweep.
        refill_valid_i = 1'b1; refill_index_i = 6'd9; refill_tag_i = 20'h22;
        cyc();
        refill_valid_i = 1'b0;
        req_valid_i = 1'b1; req_index_i = 6'd9; req_tag_i = 20'h22;
        cyc();
        req_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        chk("hit_9_flush", 32'({rsp_valid_o, rsp_hit_o}), 32'b11);
        cyc();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("flush_sweep0", 32'({busy_o, tag_we_o, tag_addr_o}), 32'b11_000000);
        cyc();
        wait_idle();
        req_valid_i = 1'b1; req_index_i = 6'd9; req_tag_i = 20'h22;
        cyc();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("miss_9_after_flush", 32'({rsp_valid_o, rsp_hit_o}), 32'b10);
        cyc();

        // Reset at sweep index 30.
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        n = 0;
        @(negedge clk_i);
        while (!(busy_o && tag_addr_o == 6'd29) && n < 100) begin
            cyc();
            @(negedge clk_i);
            n++;
        end
        chk("reach_idx29", 32'(tag_addr_o), 32'd29);
        cyc();
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_strobes", 32'({tag_en_o, tag_we_o, tag_be_o}), 32'd0);
        cyc();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("restart_idx0", 32'({tag_en_o, tag_we_o, tag_addr_o}), 32'b11_000000);
        cyc();
        wait_idle();

        // Reset while a lookup is pending drops the response.
        req_valid_i = 1'b1; req_index_i = 6'd3; req_tag_i = 20'h1;
        cyc();
        req_valid_i = 1'b0; rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_rsp", 32'(rsp_valid_o), 32'd0);
        cyc();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("no_late_rsp", 32'(rsp_valid_o), 32'd0);
        cyc();
        wait_idle();

        // Random refill/lookup/flush traffic on a small index/tag space.
        for (int i = 0; i < 800; i++) begin
            flush_i        = ($urandom_range(0, 59) == 0);
            refill_valid_i = ($urandom_range(0, 3) == 0);
            refill_index_i = 6'($urandom_range(0, 7));
            refill_tag_i   = 20'($urandom_range(0, 3));
            req_valid_i    = ($urandom_range(0, 1) == 1);
            req_index_i    = 6'($urandom_range(0, 7));
            req_tag_i      = 20'($urandom_range(0, 3));
            cyc();
        end
        flush_i = 1'b0; refill_valid_i = 1'b0; req_valid_i = 1'b0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscmakers_icache_tag_ctrl.md
# riscmakers_icache_tag_ctrl

Access controller for the instruction-cache tag store SRAM. It sequences every access to the tag store: a full-array invalidation sweep after reset and on flush, single-cycle refill writes, and pipelined tag lookups that return hit/miss one cycle after acceptance. It sits between the icache datapath/miss logic and `riscmakers_icache_tag_store`, which it drives through that store's enable/write/byte-enable/address/data port.

## Interface
Parameters:
- `TAG_WIDTH`, default `riscmakers_pkg::ICACHE_TAG_WIDTH`: tag bits, stored in entry bits `[TAG_WIDTH-1:0]`.
- `DATA_WIDTH`, default `riscmakers_pkg::ICACHE_TAG_STORE_DATA_WIDTH`: tag store entry width.
  - Must be a multiple of 8.
  - Must be greater than `TAG_WIDTH`.
- `VALID_BIT_POS`, default `riscmakers_pkg::ICACHE_TAG_STORE_VALID_BIT_POSITION`: valid bit index.
  - Must satisfy `TAG_WIDTH <= VALID_BIT_POS < DATA_WIDTH`.
- `NUM_WORDS`, default `wt_cache_pkg::ICACHE_NUM_WORDS`: number of tag store entries (sets). Must be a power of two, ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `flush_i` in 1: request invalidation of the whole array (level, sampled each cycle).
- `busy_o` out 1: sweep in progress.
- `req_valid_i` in 1: lookup request.
- `req_ready_o` out 1: lookup accepted when both valid and ready are high.
- `req_index_i` in `$clog2(NUM_WORDS)`: lookup set index.
- `req_tag_i` in `TAG_WIDTH`: lookup tag.
- `rsp_valid_o` out 1: single-cycle response pulse. There is no backpressure.
- `rsp_hit_o` out 1: hit result. Meaningful only while `rsp_valid_o` is high; otherwise 0.
- `refill_valid_i` in 1: write-tag request.
- `refill_ready_o` out 1: refill accepted when both valid and ready are high.
- `refill_index_i` in `$clog2(NUM_WORDS)`: refill set index.
- `refill_tag_i` in `TAG_WIDTH`: refill tag.
- `tag_en_o` out 1: SRAM enable.
- `tag_we_o` out 1: SRAM write enable.
- `tag_be_o` out `DATA_WIDTH/8`: SRAM byte enables.
- `tag_addr_o` out `$clog2(NUM_WORDS)`: SRAM address.
- `tag_wdata_o` out `DATA_WIDTH`: SRAM write data.
- `tag_rdata_i` in `DATA_WIDTH`: SRAM read data. Valid the cycle after a read is issued, and unchanged by intervening writes.

## Operation
- States:
  - SWEEP: counter `sweep_idx` runs from 0 to `NUM_WORDS-1`.
  - IDLE: serves requests.
- Reset value (synchronous, `rst_ni` low at the edge):
  - state = SWEEP, `sweep_idx` = 0, response-pending = 0.
  - While `rst_ni` is low, all SRAM strobes are gated: `tag_en_o`=0, `tag_we_o`=0, `tag_be_o`=0.
- Output values while `rst_ni` is low: `busy_o`=1, `req_ready_o`=0, `refill_ready_o`=0, `rsp_valid_o`=0, `rsp_hit_o`=0.
- SWEEP, each cycle:
  - Write one entry: `tag_en_o`=1, `tag_we_o`=1, `tag_be_o`=all ones, `tag_addr_o`=`sweep_idx`, `tag_wdata_o`=0 (which clears the valid bit).
  - Increment `sweep_idx`.
  - After writing index `NUM_WORDS-1`, go to IDLE and return the counter to 0.
  - Both ready outputs are 0. `flush_i` is ignored.
- IDLE, per cycle, fixed priority flush > refill > lookup:
  - `flush_i`=1:
    - Both readies are 0.
    - No SRAM access this cycle.
    - Next state is SWEEP.
  - Otherwise, if `refill_valid_i`=1:
    - `refill_ready_o`=1 and `req_ready_o`=0.
    - Write `{VALID=1, tag=refill_tag_i, other bits 0}` to `refill_index_i` with all byte enables set.
  - Otherwise: `req_ready_o`=1. If `req_valid_i`=1, issue a read of `req_index_i` (`tag_en_o`=1, `tag_we_o`=0, `tag_be_o`=0) and register `req_tag_i`.
- Response:
  - Asserted the cycle after acceptance, in any state.
  - `rsp_hit_o` = `tag_rdata_i[VALID_BIT_POS]` AND (`tag_rdata_i[TAG_WIDTH-1:0]` == registered tag).
  - The compare is combinational from `tag_rdata_i`.
- When SRAM strobes are not asserted: `tag_addr_o` and `tag_wdata_o` are don't-care; drive them to 0.

## Timing
- Lookup latency: 1 cycle (accepted in N, response in N+1). Throughput: one lookup per cycle back to back.
- Refill completes in 1 cycle. A lookup of the same index accepted in the cycle after the refill hits.
- Refill at index X in cycle N+1, after a lookup of X accepted in N: the N+1 response reflects the pre-refill contents.
- `flush_i` sampled in cycle N while a response is pending:
  - The response is still delivered in N+1.
  - The sweep writes index 0 in N+1.
  - `busy_o` is high from N+1.
- Sweep length: exactly `NUM_WORDS` write cycles.
  - After reset release (first cycle with `rst_ni`=1 is cycle 0): `busy_o` falls and `req_ready_o` can first be 1 in cycle `NUM_WORDS`.
- `busy_o` is 1 in SWEEP and 0 in IDLE.
- Readies depend combinationally on the state, `flush_i` and `refill_valid_i`. They never depend on `req_valid_i`.
- Reset mid-lookup: the pending response is dropped (`rsp_valid_o`=0 in the next cycle).
- Reset mid-sweep: the sweep restarts at index 0.

## Test plan
- Reset release with `NUM_WORDS`=64 -> exactly 64 writes with data 0 to addresses 0..63 in order; `busy_o` is 1 for 64 cycles; `req_ready_o` rises in cycle 64.
- Refill index 5 with tag 0x3A, then look up (5, 0x3A) and (5, 0x3B) back to back -> responses in consecutive cycles: hit=1, then hit=0.
- Simultaneous refill of (7, 0x11) and lookup of (7, 0x11) -> refill accepted, `req_ready_o`=0; lookup accepted the next cycle returns hit=1.
- Lookup of (9, 0x22) with the entry valid, and `flush_i` raised in the response cycle -> hit=1 delivered; sweep starts; a lookup of (9, 0x22) after the sweep returns hit=0.
- `rst_ni` asserted at sweep index 30 and at a pending lookup -> no response pulse; the sweep restarts at 0 and all SRAM strobes are 0 while in reset.
- Random refill/lookup/flush traffic against a reference model -> every hit result matches the model; no SRAM access is issued while `busy_o` is high other than sweep writes.
